// File: rtl/csr_issue_pkg.sv
// csr_issue_pkg
// Shared definitions for the CSR issue stage: register-bus width, SYSTEM
// opcode, CSR operation encodings, FSM state encoding and a small decode
// helper used at instruction accept time.
package csr_issue_pkg;

    localparam int         REG_BUS       = 64;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [1:0] CSR_RW = 2'b01;
    localparam logic [1:0] CSR_RS = 2'b10;
    localparam logic [1:0] CSR_RC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // A CSR write happens for every RW, and for RS/RC only when the
    // rs1/uimm field is non-zero (CSRRS/CSRRC with x0 are pure reads).
    function automatic logic write_required(input logic [1:0] op,
                                            input logic [4:0] src_field);
        return (op == CSR_RW) || (src_field != 5'd0);
    endfunction

endpackage

// File: rtl/csr_issue.sv
// csr_issue
// Issues one Zicsr SYSTEM instruction at a time to a single implemented CSR
// (CSR_CYCLE_ADDR). Sequence per instruction: IDLE -> READ -> [WRITE] -> RESP,
// or IDLE -> RESP directly for an illegal instruction.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        instruction offer / accept handshake
//   inst, rs1_data           SYSTEM instruction word and rs1 value
//   csr_addr/rena/wena/op    CSR unit control
//   csr_wdata, csr_rdata     CSR unit write operand / combinational read data
//   out_valid/out_ready      writeback handshake
//   out_rd/rd_wen/rd_data    writeback destination, enable, old CSR value
//   out_illegal              illegal-instruction flag
//   busy                     high whenever the FSM is not in IDLE
module csr_issue
    import csr_issue_pkg::*;
#(
    parameter logic [11:0] CSR_CYCLE_ADDR = 12'hB00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst,
    input  logic [REG_BUS-1:0] rs1_data,
    output logic [11:0]        csr_addr,
    output logic               csr_rena,
    output logic               csr_wena,
    output logic [1:0]         csr_op,
    output logic [REG_BUS-1:0] csr_wdata,
    input  logic [REG_BUS-1:0] csr_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         out_rd,
    output logic               out_rd_wen,
    output logic [REG_BUS-1:0] out_rd_data,
    output logic               out_illegal,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [4:0]         rd_q;
    logic [1:0]         op_q;
    logic [11:0]        addr_q;
    logic [REG_BUS-1:0] operand_q;
    logic [REG_BUS-1:0] old_q;
    logic               illegal_q;
    logic               wreq_q;
    logic               ready_q;

    // Decode of the offered instruction, consumed only on accept.
    logic [2:0]         dec_funct3_s;
    logic [1:0]         dec_op_s;
    logic [11:0]        dec_addr_s;
    logic               dec_wreq_s;
    logic               dec_illegal_s;
    logic [REG_BUS-1:0] dec_operand_s;
    logic               accept_s;

    assign dec_funct3_s  = inst[14:12];
    assign dec_op_s      = dec_funct3_s[1:0];
    assign dec_addr_s    = inst[31:20];
    assign dec_wreq_s    = write_required(dec_op_s, inst[19:15]);
    assign dec_operand_s = dec_funct3_s[2] ? {{(REG_BUS-5){1'b0}}, inst[19:15]} : rs1_data;
    // addr[11:10]==11 marks a read-only CSR; writing it is illegal.
    assign dec_illegal_s = (inst[6:0] != OPCODE_SYSTEM) ||
                           (dec_op_s == 2'b00) ||
                           (dec_addr_s != CSR_CYCLE_ADDR) ||
                           ((dec_addr_s[11:10] == 2'b11) && dec_wreq_s);
    assign accept_s      = in_valid && in_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = dec_illegal_s ? ST_RESP : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (wreq_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction fields, old CSR value and the post-reset ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q      <= 5'd0;
            op_q      <= 2'b00;
            addr_q    <= 12'd0;
            operand_q <= {REG_BUS{1'b0}};
            old_q     <= {REG_BUS{1'b0}};
            illegal_q <= 1'b0;
            wreq_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            // in_ready stays low until the first edge after reset release.
            ready_q <= 1'b1;
            if (accept_s) begin
                rd_q      <= inst[11:7];
                op_q      <= dec_op_s;
                addr_q    <= dec_addr_s;
                operand_q <= dec_operand_s;
                illegal_q <= dec_illegal_s;
                wreq_q    <= dec_wreq_s;
                old_q     <= {REG_BUS{1'b0}};
            end else if (state_q == ST_READ) begin
                old_q <= csr_rdata;
            end else begin
                old_q <= old_q;
            end
        end
    end

    // Moore outputs decoded purely from registered state, so a reset
    // (which clears state asynchronously) drops every strobe at once.
    always_comb begin
        in_ready    = 1'b0;
        busy        = 1'b0;
        csr_addr    = 12'd0;
        csr_rena    = 1'b0;
        csr_wena    = 1'b0;
        csr_op      = 2'b00;
        csr_wdata   = {REG_BUS{1'b0}};
        out_valid   = 1'b0;
        out_rd      = 5'd0;
        out_rd_wen  = 1'b0;
        out_rd_data = {REG_BUS{1'b0}};
        out_illegal = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = ready_q;
            ST_READ: begin
                busy     = 1'b1;
                csr_addr = addr_q;
                csr_op   = op_q;
                // CSRRW to x0 must not cause read side effects.
                csr_rena = (rd_q != 5'd0) || (op_q != CSR_RW);
            end
            ST_WRITE: begin
                busy      = 1'b1;
                csr_addr  = addr_q;
                csr_op    = op_q;
                csr_wena  = 1'b1;
                csr_wdata = operand_q;
            end
            ST_RESP: begin
                busy        = 1'b1;
                out_valid   = 1'b1;
                out_rd      = rd_q;
                out_rd_wen  = (rd_q != 5'd0) && !illegal_q;
                out_rd_data = old_q;
                out_illegal = illegal_q;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule
